// File: rtl/sensor_packet_streamer_pkg.sv
// sensor_packet_streamer_pkg: shared FSM state type, counter widths and frame geometry helpers
package sensor_stream_pkg;
  localparam int SEQ_WIDTH = 32;
  localparam int DROP_CNT_WIDTH = 16;
  typedef enum logic [2:0] {IDLE, CAPTURE, HEADER, SEQ, PAYLOAD} state_e;
  function automatic int pay_words(input int nch, input int spw);
    return (nch + spw - 1) / spw;
  endfunction
  function automatic int frame_words(input int hw, input int nch, input int spw);
    return hw + 1 + pay_words(nch, spw);
  endfunction
  function automatic int eop_empty(input int nch, input int sw, input int spw);
    return ((pay_words(nch, spw) * spw - nch) * sw) / 8;
  endfunction
  function automatic int empty_w(input int dw);
    return (dw / 8 > 1) ? $clog2(dw / 8) : 1;
  endfunction
endpackage

// File: rtl/sensor_packet_streamer_if.sv
// sensor_packet_streamer_if: Avalon-ST transmit link from the packet streamer to the MAC
interface sensor_packet_streamer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int EMPTY_W = 2
);
  logic Tx_Valid_xSO;
  logic [DATA_WIDTH-1:0] Tx_Data_xDO;
  logic Tx_Sop_xSO;
  logic Tx_Eop_xSO;
  logic [EMPTY_W-1:0] Tx_Empty_xSO;
  logic [1:0] Tx_Error_xSO;
  logic Tx_Ready_xSI;
  modport master (
    output Tx_Valid_xSO, Tx_Data_xDO, Tx_Sop_xSO, Tx_Eop_xSO, Tx_Empty_xSO, Tx_Error_xSO,
    input Tx_Ready_xSI
  );
  modport slave (
    input Tx_Valid_xSO, Tx_Data_xDO, Tx_Sop_xSO, Tx_Eop_xSO, Tx_Empty_xSO, Tx_Error_xSO,
    output Tx_Ready_xSI
  );
endinterface

// File: rtl/sensor_packet_streamer_period_timer.sv
// period_timer: down-counter that ticks once every Period cycles while enabled
module period_timer #(
  parameter int PERIOD_WIDTH = 32
) (
  input  logic                    Clock_xCI,
  input  logic                    Reset_xSI,
  input  logic                    Enable_xSI,
  input  logic [PERIOD_WIDTH-1:0] Period_xDI,
  output logic                    Tick_xSO
);
  logic [PERIOD_WIDTH-1:0] cnt_q;
  logic run;
  assign run = Enable_xSI && (Period_xDI != '0);
  assign Tick_xSO = run && (cnt_q == '0);
  // Reload while idle so a fresh enable waits a full period before the first tick
  always_ff @(posedge Clock_xCI) begin
    if (Reset_xSI || !run || cnt_q == '0) cnt_q <= Period_xDI - 1'b1;
    else cnt_q <= cnt_q - 1'b1;
  end
endmodule

// File: rtl/sensor_packet_streamer.sv
// sensor_packet_streamer: snapshots sensor samples and streams header/sequence/payload frames over Avalon-ST
module sensor_packet_streamer
  import sensor_stream_pkg::*;
#(
  parameter int NUM_CHANNELS = 6,
  parameter int SAMPLE_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int HEADER_WORDS = 11,
  parameter int PERIOD_WIDTH = 32
) (
  input  logic                                 Clock_xCI,
  input  logic                                 Reset_xSI,
  input  logic                                 Enable_xSI,
  input  logic                                 Periodic_xSI,
  input  logic [PERIOD_WIDTH-1:0]              Period_xDI,
  input  logic                                 Send_Packet_xSI,
  input  logic [HEADER_WORDS*DATA_WIDTH-1:0]   Header_xDI,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] Samples_xDI,
  sensor_packet_streamer_if.master             tx,
  output logic                                 Busy_xSO,
  output logic [SEQ_WIDTH-1:0]                 Seq_xDO,
  output logic [DROP_CNT_WIDTH-1:0]            Dropped_Count_xDO
);
  localparam int SPW = DATA_WIDTH / SAMPLE_WIDTH;
  localparam int PAY = pay_words(NUM_CHANNELS, SPW);
  localparam int FRAME = frame_words(HEADER_WORDS, NUM_CHANNELS, SPW);
  localparam int EOPE = eop_empty(NUM_CHANNELS, SAMPLE_WIDTH, SPW);
  localparam int EMPTY_W = empty_w(DATA_WIDTH);
  localparam int W_W = $clog2(FRAME);
  localparam int PAD_W = PAY * SPW * SAMPLE_WIDTH;

  if (DATA_WIDTH % SAMPLE_WIDTH != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of SAMPLE_WIDTH");
  end

  state_e state_q;
  logic [W_W-1:0] w_q;
  logic [HEADER_WORDS*DATA_WIDTH-1:0] hdr_q;
  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] smp_q;
  logic [SEQ_WIDTH-1:0] snap_q, seq_q;
  logic [DROP_CNT_WIDTH-1:0] drop_q;
  logic send_q, busy_q, valid_q, sop_q, eop_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [EMPTY_W-1:0] empty_q;

  logic tick, trig, ready, last;
  logic [W_W-1:0] nxt_w;
  state_e nxt_st;
  logic [PAD_W-1:0] smp_pad;
  logic [DATA_WIDTH-1:0] frm [FRAME];

  period_timer #(.PERIOD_WIDTH(PERIOD_WIDTH)) u_timer (
    .Clock_xCI (Clock_xCI),
    .Reset_xSI (Reset_xSI),
    .Enable_xSI(Enable_xSI && Periodic_xSI),
    .Period_xDI(Period_xDI),
    .Tick_xSO  (tick)
  );

  assign ready = tx.Tx_Ready_xSI;
  assign trig = Enable_xSI && ((!Periodic_xSI && Send_Packet_xSI && !send_q) || (Periodic_xSI && tick));
  assign nxt_w = w_q + 1'b1;
  assign last = nxt_w == W_W'(FRAME - 1);
  assign nxt_st = nxt_w < W_W'(HEADER_WORDS) ? HEADER : nxt_w == W_W'(HEADER_WORDS) ? SEQ : PAYLOAD;
  assign smp_pad = PAD_W'(smp_q);

  // Whole frame as a word array; payload lane 0 sits in the MS bits (network order)
  always_comb begin
    frm = '{default: '0};
    for (int i = 0; i < HEADER_WORDS; i++)
      frm[i] = hdr_q[(HEADER_WORDS-1-i)*DATA_WIDTH +: DATA_WIDTH];
    frm[HEADER_WORDS] = DATA_WIDTH'(snap_q);
    for (int p = 0; p < PAY; p++)
      for (int l = 0; l < SPW; l++)
        frm[HEADER_WORDS+1+p][DATA_WIDTH-1-l*SAMPLE_WIDTH -: SAMPLE_WIDTH] =
          smp_pad[(p*SPW+l)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
  end

  always_ff @(posedge Clock_xCI) begin
    if (Reset_xSI) begin
      state_q <= IDLE;
      w_q <= '0;
      hdr_q <= '0;
      smp_q <= '0;
      snap_q <= '0;
      seq_q <= '0;
      drop_q <= '0;
      send_q <= 1'b0;
      busy_q <= 1'b0;
      valid_q <= 1'b0;
      sop_q <= 1'b0;
      eop_q <= 1'b0;
      data_q <= '0;
      empty_q <= '0;
    end else begin
      send_q <= Send_Packet_xSI;
      if (trig && state_q != IDLE && drop_q != '1) drop_q <= drop_q + 1'b1;
      case (state_q)
        IDLE: if (trig) begin
          state_q <= CAPTURE;
          busy_q <= 1'b1;
          hdr_q <= Header_xDI;
          smp_q <= Samples_xDI;
          snap_q <= seq_q;
        end
        CAPTURE: begin
          state_q <= HEADER;
          w_q <= '0;
          valid_q <= 1'b1;
          sop_q <= 1'b1;
          eop_q <= 1'b0;
          empty_q <= '0;
          data_q <= frm[0];
        end
        default: if (valid_q && ready) begin
          if (eop_q) begin
            state_q <= IDLE;
            busy_q <= 1'b0;
            valid_q <= 1'b0;
            sop_q <= 1'b0;
            eop_q <= 1'b0;
            empty_q <= '0;
            data_q <= '0;
            seq_q <= seq_q + 1'b1;
          end else begin
            state_q <= nxt_st;
            w_q <= nxt_w;
            sop_q <= 1'b0;
            eop_q <= last;
            empty_q <= last ? EMPTY_W'(EOPE) : '0;
            data_q <= frm[nxt_w];
          end
        end
      endcase
    end
  end

  assign tx.Tx_Valid_xSO = valid_q;
  assign tx.Tx_Data_xDO = data_q;
  assign tx.Tx_Sop_xSO = sop_q;
  assign tx.Tx_Eop_xSO = eop_q;
  assign tx.Tx_Empty_xSO = empty_q;
  assign tx.Tx_Error_xSO = '0;
  assign Busy_xSO = busy_q;
  assign Seq_xDO = seq_q;
  assign Dropped_Count_xDO = drop_q;
endmodule

// File: tb/tb_sensor_packet_streamer.sv
// tb_sensor_packet_streamer: directed checks of framing, back-pressure, periodic triggering, drops and reset
module tb_sensor_packet_streamer;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1, periodic = 1'b0, send = 1'b0, ready = 1'b1;
  logic [31:0] period = '0;
  logic [127:0] header;
  logic [95:0] samples;
  logic busy_a, busy_b;
  logic [31:0] seq_a, seq_b;
  logic [15:0] drop_a, drop_b;

  initial forever #5 clk = ~clk;

  sensor_packet_streamer_if #(.DATA_WIDTH(32), .EMPTY_W(2)) tx_a ();
  sensor_packet_streamer_if #(.DATA_WIDTH(32), .EMPTY_W(2)) tx_b ();
  assign tx_a.Tx_Ready_xSI = ready;
  assign tx_b.Tx_Ready_xSI = ready;

  sensor_packet_streamer #(.HEADER_WORDS(4)) dut_a (
    .Clock_xCI(clk), .Reset_xSI(rst), .Enable_xSI(en), .Periodic_xSI(periodic),
    .Period_xDI(period), .Send_Packet_xSI(send), .Header_xDI(header), .Samples_xDI(samples),
    .tx(tx_a), .Busy_xSO(busy_a), .Seq_xDO(seq_a), .Dropped_Count_xDO(drop_a)
  );

  sensor_packet_streamer #(.NUM_CHANNELS(5), .HEADER_WORDS(4)) dut_b (
    .Clock_xCI(clk), .Reset_xSI(rst), .Enable_xSI(en), .Periodic_xSI(periodic),
    .Period_xDI(period), .Send_Packet_xSI(send), .Header_xDI(header), .Samples_xDI(samples[79:0]),
    .tx(tx_b), .Busy_xSO(busy_b), .Seq_xDO(seq_b), .Dropped_Count_xDO(drop_b)
  );

  int checks = 0, failures = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [31:0] wa [8], wb [8], ew [8];
  logic [7:0] sop_m, eop_m, eopb_m;
  logic [1:0] empty_last, emptyb_last;
  int n, cyc, pulse_at = -1;
  bit stall_bad, gap_bad;

  task automatic start_frame(input string t);
    send = 1'b1;
    @(negedge clk);
    check({t, "_cap_busy"}, busy_a, 1);
    check({t, "_cap_valid"}, tx_a.Tx_Valid_xSO, 0);
    send = 1'b0;
    @(negedge clk);
    check({t, "_sop_t2"}, {tx_a.Tx_Valid_xSO, tx_a.Tx_Sop_xSO}, 2'b11);
  endtask

  task automatic collect(input bit toggle);
    logic [33:0] prev;
    bit stalled, done;
    n = 0; cyc = 0; stall_bad = 0; gap_bad = 0; stalled = 0; done = 0; prev = '0;
    sop_m = '0; eop_m = '0; eopb_m = '0;
    for (int c = 0; c < 64 && !done; c++) begin
      ready = toggle ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
      send = (c == pulse_at);
      if (stalled && {tx_a.Tx_Sop_xSO, tx_a.Tx_Eop_xSO, tx_a.Tx_Data_xDO} != prev) stall_bad = 1;
      if (n > 0 && !tx_a.Tx_Valid_xSO) gap_bad = 1;
      if (tx_a.Tx_Valid_xSO && ready) begin
        if (n < 8) begin
          wa[n] = tx_a.Tx_Data_xDO;
          wb[n] = tx_b.Tx_Data_xDO;
          sop_m[n] = tx_a.Tx_Sop_xSO;
          eop_m[n] = tx_a.Tx_Eop_xSO;
          eopb_m[n] = tx_b.Tx_Eop_xSO;
        end
        n++;
        empty_last = tx_a.Tx_Empty_xSO;
        emptyb_last = tx_b.Tx_Empty_xSO;
        done = tx_a.Tx_Eop_xSO;
      end
      stalled = tx_a.Tx_Valid_xSO && !ready;
      prev = {tx_a.Tx_Sop_xSO, tx_a.Tx_Eop_xSO, tx_a.Tx_Data_xDO};
      cyc = c + 1;
      if (!done) @(negedge clk);
    end
    check("frame_done", done, 1);
  endtask

  task automatic check_frame(input string t, input logic [31:0] seqw);
    ew[4] = seqw;
    check({t, "_words"}, n, 8);
    for (int i = 0; i < 8; i++) check($sformatf("%s_w%0d", t, i), wa[i], ew[i]);
    check({t, "_sop_mask"}, sop_m, 8'h01);
    check({t, "_eop_mask"}, eop_m, 8'h80);
    check({t, "_empty"}, empty_last, 0);
  endtask

  int ns, ne, st [4];

  initial begin
    header = {32'hA0000000, 32'hA1111111, 32'hA2222222, 32'hA3333333};
    samples = {16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001};
    ew = '{32'hA0000000, 32'hA1111111, 32'hA2222222, 32'hA3333333, 32'h0,
           32'h00010002, 32'h00030004, 32'h00050006};
    repeat (3) @(negedge clk);
    check("rst_valid", tx_a.Tx_Valid_xSO, 0);
    check("rst_outs", {tx_a.Tx_Sop_xSO, tx_a.Tx_Eop_xSO, tx_a.Tx_Empty_xSO, tx_a.Tx_Error_xSO, busy_a}, 0);
    check("rst_data", tx_a.Tx_Data_xDO, 0);
    check("rst_seq_drop", {seq_a, drop_a}, 0);
    rst = 1'b0;
    @(negedge clk);

    // basic frame, plus 5-channel instance running alongside
    start_frame("t1");
    collect(0);
    check_frame("t1", 32'h0);
    check("t1_cycles", cyc, 8);
    check("t2_last_word", wb[7], 32'h00050000);
    check("t2_mid_word", wb[6], 32'h00030004);
    check("t2_empty", emptyb_last, 2);
    check("t2_eop_mask", eopb_m, 8'h80);
    @(negedge clk);
    check("t1_seq", seq_a, 1);
    check("t1_idle", {busy_a, tx_a.Tx_Valid_xSO}, 0);

    // back-pressure; inputs changed after capture must not leak into the frame
    samples = {16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111};
    start_frame("t3");
    samples = '0;
    header = '0;
    collect(1);
    ew[5] = 32'h11112222; ew[6] = 32'h33334444; ew[7] = 32'h55556666;
    check_frame("t3", 32'h1);
    check("t3_stall_stable", stall_bad, 0);
    check("t3_valid_gap", gap_bad, 0);
    check("t3_cycles", cyc, 16);
    header = {32'hA0000000, 32'hA1111111, 32'hA2222222, 32'hA3333333};
    samples = {16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001};
    ew[5] = 32'h00010002; ew[6] = 32'h00030004; ew[7] = 32'h00050006;
    @(negedge clk);
    check("t3_seq", seq_a, 2);

    // trigger during frame dropped; trigger right after Eop accepted
    pulse_at = 3;
    start_frame("t5a");
    collect(0);
    pulse_at = -1;
    check_frame("t5a", 32'h2);
    check("t5_dropped", drop_a, 1);
    @(negedge clk);
    check("t5_idle_e1", busy_a, 0);
    start_frame("t5b");
    collect(0);
    check_frame("t5b", 32'h3);
    check("t5_dropped_hold", drop_a, 1);
    @(negedge clk);
    check("t5_seq", seq_a, 4);

    // periodic, period 20
    ready = 1'b1;
    period = 20;
    @(negedge clk);
    periodic = 1'b1;
    ns = 0;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      if (tx_a.Tx_Valid_xSO && tx_a.Tx_Sop_xSO) begin
        if (ns < 4) st[ns] = i;
        ns++;
      end
      if (i == 70) periodic = 1'b0;
    end
    check("t4_sop_count", ns, 3);
    check("t4_sop0", st[0], 21);
    check("t4_sop1", st[1], 41);
    check("t4_sop2", st[2], 61);
    check("t4_seq", seq_a, 7);
    check("t4_drop", drop_a, 1);

    // periodic, period 5: one drop per frame, frames still complete
    period = 5;
    @(negedge clk);
    periodic = 1'b1;
    ns = 0; ne = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 40) periodic = 1'b0;
      if (tx_a.Tx_Valid_xSO && tx_a.Tx_Sop_xSO) ns++;
      if (tx_a.Tx_Valid_xSO && tx_a.Tx_Eop_xSO && ready) ne++;
    end
    check("t4b_sops", ns, 4);
    check("t4b_eops", ne, 4);
    check("t4b_drop", drop_a, 5);
    check("t4b_seq", seq_a, 11);
    check("t4b_busy", busy_a, 0);

    // saturation of the drop counter
    force dut_a.drop_q = 16'hFFFE;
    @(negedge clk);
    release dut_a.drop_q;
    @(negedge clk);
    check("t4c_forced", drop_a, 16'hFFFE);
    periodic = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (i == 30) periodic = 1'b0;
    end
    check("t4c_saturate", drop_a, 16'hFFFF);
    check("t4c_seq", seq_a, 14);

    // reset mid-frame
    start_frame("t6a");
    repeat (3) @(negedge clk);
    check("t6_word3", tx_a.Tx_Data_xDO, 32'hA3333333);
    rst = 1'b1;
    @(negedge clk);
    check("t6_valid_drop", {tx_a.Tx_Valid_xSO, tx_a.Tx_Eop_xSO}, 0);
    check("t6_seq_drop", {seq_a, drop_a}, 0);
    rst = 1'b0;
    @(negedge clk);
    start_frame("t6b");
    collect(0);
    check_frame("t6b", 32'h0);
    @(negedge clk);
    check("t6_seq", seq_a, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
